// File: rtl/ascii_result_tx_if.sv
// Bundle of the capture inputs and the character output channel of ascii_result_tx.
// Producer (master) drives load/S/C5/E and char_ready; the transmitter (slave) drives the rest.
`timescale 1ns/1ps

interface ascii_result_tx_if;
    logic       load;
    logic [4:0] S;
    logic       C5;
    logic       E;
    // Valid/ready: a character transfers on every rising edge where char_valid
    // and char_ready are both 1; char_valid never drops and char_out never changes
    // while waiting for char_ready, and char_ready is ignored when char_valid is 0.
    logic       char_ready;
    logic [7:0] char_out;
    logic       char_valid;
    logic       busy;
    logic       done;
    logic [2:0] state_dbg;

    modport master (
        output load, S, C5, E, char_ready,
        input  char_out, char_valid, busy, done, state_dbg
    );

    modport slave (
        input  load, S, C5, E, char_ready,
        output char_out, char_valid, busy, done, state_dbg
    );
endinterface

// File: rtl/ascii_result_tx.sv
// Captures an adder result, converts it to two ASCII decimal digits by repeated
// subtraction and streams them out. Define TX_LF_EN to append a line feed per result.
`timescale 1ns/1ps

module ascii_result_tx (
    input logic clk,
    input logic reset,
    ascii_result_tx_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CONV    = 3'd1,
        SEND_T  = 3'd2,
        SEND_O  = 3'd3,
`ifdef TX_LF_EN
        SEND_LF = 3'd4,
`endif
        FIN     = 3'd5
    } state_t;

    state_t     state;
    logic [5:0] rem;
    logic [2:0] tens;
    logic [7:0] char_out_q;
    logic       char_valid_q;
    logic       busy_q;
    logic       done_q;
    logic       handshake;

    assign handshake      = char_valid_q && bus.char_ready;
    assign bus.char_out   = char_out_q;
    assign bus.char_valid = char_valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.state_dbg  = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            rem          <= 6'd0;
            tens         <= 3'd0;
            char_out_q   <= 8'h00;
            char_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.load) begin
                        // E marks C5 as the true MSB; otherwise the value is just S.
                        rem    <= bus.E ? {bus.C5, bus.S} : {1'b0, bus.S};
                        tens   <= 3'd0;
                        busy_q <= 1'b1;
                        state  <= CONV;
                    end
                end
                CONV: begin
                    if (rem >= 6'd10) begin
                        rem  <= rem - 6'd10;
                        tens <= tens + 3'd1;
                    end else begin
                        char_out_q   <= 8'h30 + {5'd0, tens};
                        char_valid_q <= 1'b1;
                        state        <= SEND_T;
                    end
                end
                SEND_T: begin
                    if (handshake) begin
                        char_out_q <= 8'h30 + {2'd0, rem};
                        state      <= SEND_O;
                    end
                end
                SEND_O: begin
                    if (handshake) begin
`ifdef TX_LF_EN
                        char_out_q <= 8'h0A;
                        state      <= SEND_LF;
`else
                        char_valid_q <= 1'b0;
                        done_q       <= 1'b1;
                        state        <= FIN;
`endif
                    end
                end
`ifdef TX_LF_EN
                SEND_LF: begin
                    if (handshake) begin
                        char_valid_q <= 1'b0;
                        done_q       <= 1'b1;
                        state        <= FIN;
                    end
                end
`endif
                FIN: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    char_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ascii_result_tx.sv
// Bench for ascii_result_tx: table vectors, reset/hold corner sequences and
// randomized results checked against a decimal-digit model.
`timescale 1ns/1ps

module tb_ascii_result_tx;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [7:0] exp_q[$];

    ascii_result_tx_if bus();

    ascii_result_tx dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [4:0] s;
        logic       c5;
        logic       e;
        logic [7:0] t_ch;
        logic [7:0] o_ch;
    } vec_t;

    // ---------------- driver: one full result ----------------
    task automatic run_one(input logic [4:0] s, input logic c5, input logic e,
                           input logic [7:0] t_ch, input logic [7:0] o_ch,
                           input int hold, input bit rnd);
        int v, k, held;
        bit seen_valid, finished;
        v = e ? int'({c5, s}) : int'(s);
        exp_q.delete();
        exp_q.push_back(t_ch);
        exp_q.push_back(o_ch);
`ifdef TX_LF_EN
        exp_q.push_back(8'h0A);
`endif
        bus.S = s;
        bus.C5 = c5;
        bus.E = e;
        bus.load = 1'b1;
        bus.char_ready = 1'b0;
        step();
        bus.load = 1'b0;
        bus.S = 5'($urandom);
        bus.C5 = 1'($urandom);
        bus.E = 1'($urandom);
        check("busy_after_load", int'(bus.busy), 1);
        k = 1;
        held = 0;
        seen_valid = 1'b0;
        finished = 1'b0;
        while (!finished && k < 300) begin
            if (bus.char_valid) begin
                if (!seen_valid) begin
                    seen_valid = 1'b1;
                    check("first_valid_cycle", k, 2 + v / 10);
                end
                if (exp_q.size() == 0) begin
                    check("extra_char", int'(bus.char_out), -1);
                    finished = 1'b1;
                end else begin
                    check("char_out", int'(bus.char_out), int'(exp_q[0]));
                end
                if (held < hold) begin
                    bus.char_ready = 1'b0;
                    held++;
                end else begin
                    bus.char_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                if (bus.char_ready && exp_q.size() != 0) void'(exp_q.pop_front());
            end else begin
                if (seen_valid && exp_q.size() == 0) begin
                    check("done_pulse", int'(bus.done), 1);
                    check("busy_in_done", int'(bus.busy), 1);
                    finished = 1'b1;
                end else begin
                    check("no_early_done", int'(bus.done), 0);
                end
                bus.char_ready = 1'($urandom_range(0, 1));
            end
            if (rnd) bus.load = 1'($urandom_range(0, 1));
            step();
            k++;
        end
        if (!finished) check("result_timeout", k, -1);
        bus.load = 1'b0;
        check("idle_after_done", int'(bus.busy), 0);
        check("done_one_cycle", int'(bus.done), 0);
        check("no_valid_in_idle", int'(bus.char_valid), 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vec_t vecs[8];
        int v;
        int n;

        vecs[0] = '{5'b01111, 1'b0, 1'b0, 8'h31, 8'h35};
        vecs[1] = '{5'b00010, 1'b1, 1'b1, 8'h33, 8'h34};
        vecs[2] = '{5'b00010, 1'b1, 1'b0, 8'h30, 8'h32};
        vecs[3] = '{5'b00000, 1'b0, 1'b0, 8'h30, 8'h30};
        vecs[4] = '{5'b11111, 1'b1, 1'b1, 8'h36, 8'h33};
        vecs[5] = '{5'b00111, 1'b0, 1'b0, 8'h30, 8'h37};
        vecs[6] = '{5'b11111, 1'b0, 1'b0, 8'h33, 8'h31};
        vecs[7] = '{5'b00000, 1'b1, 1'b1, 8'h33, 8'h32};

        reset = 1'b1;
        bus.load = 1'b1;
        bus.S = 5'd9;
        bus.C5 = 1'b0;
        bus.E = 1'b0;
        bus.char_ready = 1'b1;
        step();
        step();
        check("rst_char_out", int'(bus.char_out), 8'h00);
        check("rst_char_valid", int'(bus.char_valid), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        reset = 1'b0;
        bus.load = 1'b0;
        bus.char_ready = 1'b0;
        step();
        check("idle_no_load", int'(bus.busy), 0);

        // table vectors, back-to-back with ready held high
        for (int i = 0; i < 8; i++)
            run_one(vecs[i].s, vecs[i].c5, vecs[i].e, vecs[i].t_ch, vecs[i].o_ch, 0, 1'b0);

        // tens digit held for 5 cycles with load pulses while busy
        run_one(5'b00010, 1'b1, 1'b1, 8'h33, 8'h34, 5, 1'b1);

        // reset in the middle of CONV
        bus.S = 5'b11111; bus.C5 = 1'b1; bus.E = 1'b1; bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("conv_rst_busy", int'(bus.busy), 0);
        check("conv_rst_valid", int'(bus.char_valid), 0);
        step();
        step();
        check("conv_rst_stays_idle", int'(bus.busy), 0);
        check("conv_rst_no_valid", int'(bus.char_valid), 0);

        // reset while the ones digit is offered
        bus.S = 5'b00010; bus.C5 = 1'b1; bus.E = 1'b1; bus.load = 1'b1;
        bus.char_ready = 1'b0;
        step();
        bus.load = 1'b0;
        n = 0;
        while (!bus.char_valid && n < 20) begin
            step();
            n++;
        end
        check("sendo_seq_tens", int'(bus.char_out), 8'h33);
        bus.char_ready = 1'b1;
        step();
        check("sendo_seq_ones", int'(bus.char_out), 8'h34);
        check("sendo_seq_valid", int'(bus.char_valid), 1);
        bus.char_ready = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.char_ready = 1'b1;
        check("sendo_rst_valid", int'(bus.char_valid), 0);
        check("sendo_rst_busy", int'(bus.busy), 0);
        check("sendo_rst_char", int'(bus.char_out), 8'h00);
        check("sendo_rst_done", int'(bus.done), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("sendo_rst_no_done", int'(bus.done), 0);
            check("sendo_rst_no_valid", int'(bus.char_valid), 0);
        end
        bus.char_ready = 1'b0;
        run_one(5'b00111, 1'b0, 1'b0, 8'h30, 8'h37, 0, 1'b0);

        // randomized results against the decimal model
        for (int i = 0; i < 40; i++) begin
            logic [4:0] s;
            logic c5, e;
            s = 5'($urandom);
            c5 = 1'($urandom);
            e = 1'($urandom);
            v = e ? int'({c5, s}) : int'(s);
            run_one(s, c5, e, 8'(8'h30 + v / 10), 8'(8'h30 + v % 10),
                    $urandom_range(0, 3), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ascii_result_tx.md
# ascii_result_tx

Sequential binary-to-ASCII decimal transmitter for the adder/subtractor datapath. It captures a 5-bit result `S` together with its carry-out `C5` and overflow flag `E`, and forms the corrected unsigned value. It converts that value to two decimal digits by repeated subtraction, then streams the digits out one character per valid/ready handshake. It does the reverse of the two-character decimal entry that drives the adder, and it sits between the adder result and the character output channel.

## Interface
- Parameters: none.
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high; sampled on rising edge of `clk`.
- `load` input 1: request to capture `S`/`C5`/`E`; honoured only in IDLE.
- `S` input 5: adder result bits.
- `C5` input 1: adder carry-out.
- `E` input 1: overflow flag; 1 means `C5` is the true MSB.
- `char_ready` input 1: consumer can accept `char_out` this cycle.
- `char_out` output 8: ASCII character.
- `char_valid` output 1: `char_out` holds a character to transfer.
- `busy` output 1: conversion or transmission in progress.
- `done` output 1: one-cycle pulse after the last character is transferred.

## Operation
- Captured value V (6-bit unsigned) = E ? {C5,S} : {1'b0,S}; range 0..63.
- The block always sends exactly two digits, tens first ("00".."63"). No leading-zero suppression.
- States:
  - IDLE: `busy`=0. `load`=1 → CONV, with rem←V and tens←0.
  - CONV: if rem≥10, then rem←rem−10 and tens←tens+1, staying in CONV. Otherwise char_out←0x30+tens and go to SEND_T.
  - SEND_T: on `char_valid`&&`char_ready`, char_out←0x30+rem → SEND_O.
  - SEND_O: on handshake, go to SEND_LF when `TX_LF_EN` is defined, otherwise to FIN.
  - SEND_LF: char_out=0x0A; on handshake → FIN.
  - FIN: `done`=1 for one cycle → IDLE.
- `char_valid`=1 only in SEND_T/SEND_O/SEND_LF. `busy`=1 in every state except IDLE.
- Width rules: rem is 6 bits, tens is 3 bits (max 6). Subtraction never underflows because it is guarded by rem≥10.
- `load` asserted outside IDLE is ignored. It is not queued.
- `S`/`C5`/`E` may change freely after the capture edge.

## Timing
- Reset values: state=IDLE, `char_out`=8'h00, `char_valid`=0, `busy`=0, `done`=0, rem=0, tens=0.
- `reset` overrides everything, including mid-CONV and mid-SEND. Outputs take reset values in the cycle after the reset edge, and no partial character is completed.
- If `load` is sampled at edge N, `busy`=1 from cycle N+1.
- CONV lasts floor(V/10)+1 cycles, so the first `char_valid` occurs in cycle N+2+floor(V/10).
- While `char_valid`=1 and `char_ready`=0, `char_out` and `char_valid` hold stable.
- A transfer occurs on each edge where both `char_valid` and `char_ready` are 1. The next character appears in the following cycle.
- With `char_ready` held at 1, characters go out back-to-back at one per cycle.
- `done` is asserted in the cycle after the final handshake. IDLE follows, and `load` is accepted in the `done` cycle+1.
- `char_ready` is ignored whenever `char_valid`=0.

## Configuration
- `TX_LF_EN` defined: a third character, line feed 0x0A, is sent after the ones digit. Each result is 3 transfers.
- `TX_LF_EN` undefined: SEND_LF is not built. SEND_O goes directly to FIN, and each result is 2 transfers.

## Test plan
- S=01111, C5=0, E=0, `char_ready`=1, load at edge N → CONV 2 cycles. Output is 0x31 in cycle N+3, then 0x35, then 0x0A if `TX_LF_EN` is defined. `done` pulses the next cycle.
- S=00010, C5=1, E=1 (V=34) → output "3","4" (0x33, 0x34). With E=0 and the same S/C5 → "02" (0x30, 0x32).
- S=00000, C5=0, E=0 → first `char_valid` in cycle N+2 with 0x30, then 0x30. Boundary V=63 (S=11111, C5=1, E=1) → CONV 7 cycles, output "63".
- Hold `char_ready`=0 for 5 cycles during SEND_T → `char_out` stays 0x33 and `char_valid` stays 1. Extra `load` pulses while busy produce no effect and no second conversion.
- Assert `reset` for one cycle in SEND_O → next cycle `char_valid`=0, `busy`=0, `char_out`=0x00, and no `done` pulse. A subsequent load of V=7 yields "07" normally.
- Two results back-to-back with load asserted in the cycle after `done` → the second conversion starts correctly, with no stale tens/rem carried over.
